mont_exp_engine: RTL and testbench
==================================

# mont_exp_engine

Parametrised modular-exponentiation sequencer that computes X^E in the Montgomery domain by driving two external Montgomery multipliers in parallel through start/done handshakes. It replaces per-step CPU command sequencing (one MontMul per command) with an on-chip loop over exponent bits. It supports right-to-left square-and-multiply and a constant-sequence Montgomery ladder, followed by a final MontMul by 1 to leave the Montgomery domain. It sits between the DMA/register front end, which supplies operands, and two `montgomery` instances, which share the modulus N wired outside this block.

## Interface
Parameters:
- WIDTH, 1024: operand/result width in bits.
- EXP_WIDTH, 1024: maximum exponent length in bits; localparam LW = $clog2(EXP_WIDTH+1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- resetn  in  1  one clock; reset is synchronous and active-low.
- start  in  1  sampled only in IDLE; starts an operation.
- mode  in  1  0 = right-to-left square-and-multiply, 1 = Montgomery ladder; captured at start.
- exp  in  EXP_WIDTH  exponent E; captured at start.
- exp_len  in  LW  number of exponent bits used (valid 1..EXP_WIDTH); captured at start.
- x_tilde  in  WIDTH  base in Montgomery domain; captured into R1 at start.
- a_init  in  WIDTH  R mod N (Montgomery 1); captured into R0 at start.
- busy  out  1  high from the cycle after start until DONE.
- done  out  1  one-cycle pulse in DONE.
- error  out  1  high with done when exp_len is invalid.
- result  out  WIDTH  registered result; holds until the next start.
- mm0_start, mm1_start  out  1  one-cycle start pulses to multipliers 0 and 1.
- mm0_a, mm0_b, mm1_a, mm1_b  out  WIDTH  operands; stable from start pulse until the matching done.
- mm0_done, mm1_done  in  1  one-cycle completion pulses, at least 1 cycle after the matching start.
- mm0_result, mm1_result  in  WIDTH  valid in the cycle the matching done is high.

## Operation
- States: IDLE, ISSUE, WAIT, POST_ISSUE, POST_WAIT, DONE.
- IDLE + start:
  - Capture mode, exp, exp_len, R0 <= a_init, R1 <= x_tilde.
  - Clear result.
  - If exp_len == 0 or exp_len > EXP_WIDTH, go to DONE with error set; no multiplier is started.
  - Otherwise go to ISSUE.
- Bit index i:
  - mode 0: i starts at 0 and increments to exp_len-1.
  - mode 1: i starts at exp_len-1 and decrements to 0.
  - b = exp[i]. Bits at or above exp_len are ignored.
- ISSUE (exactly one cycle): assert the start pulses below, clear the per-channel done flags, go to WAIT.
  - Mode 0:
    - ch1 = (R1, R1).
    - ch0 = (R0, R1), issued only if b = 1.
  - Mode 1:
    - ch0 = (R0, R1), always issued.
    - ch1 = (R1, R1) if b = 1, else (R0, R0).
- WAIT:
  - Latch each channel's done flag independently; channels may finish in the same cycle or in different cycles.
  - mm*_done on a channel that was not issued is ignored.
  - On the cycle in which every issued channel has completed, write back and advance i:
    - Mode 0: R0 <= ch0 result (only if ch0 was issued); R1 <= ch1 result.
    - Mode 1, b = 1: R0 <= ch0 result; R1 <= ch1 result.
    - Mode 1, b = 0: R1 <= ch0 result; R0 <= ch1 result.
  - Next state is ISSUE if bits remain, otherwise POST_ISSUE.
- POST_ISSUE (one cycle): mm0_start with operands (R0, 1). Go to POST_WAIT.
- POST_WAIT: on mm0_done, result <= mm0_result; go to DONE.
- DONE (one cycle): done = 1, busy = 0; go to IDLE.
- General rules:
  - start is ignored outside IDLE.
  - mm*_done in IDLE or DONE is ignored.
  - Operand outputs are driven from R0/R1/state and never change while WAIT is pending.

## Timing
- Reset: state IDLE, R0 = R1 = 0, result = 0, busy = done = error = mm0_start = mm1_start = 0, all mm operands 0.
- resetn low mid-operation: all of the above take effect at the next edge. The operation is abandoned and no done is produced.
- The start edge is cycle 0. ISSUE is cycle 1; busy = 1 from cycle 1.
- With fixed multiplier latency L (start to done), each bit takes L+1 cycles.
- POST_ISSUE occurs at cycle 1 + n(L+1), where n = exp_len.
- done pulses at cycle (n+1)(L+1) + 1; result is valid from that cycle.
- Invalid exp_len: done = error = 1 in cycle 1, result = 0.
- Skewed channel completion adds cycles up to the later done; next ISSUE is the cycle after the later done.

## Test plan
Bench uses WIDTH = 16, EXP_WIDTH = 8, and a mock multiplier computing a·b mod 97 (R = 1), with a_init = 1.
- Mode 0, x_tilde = 5, exp = 8'b00001011, exp_len = 4 -> result = 71; 4 mm0_start pulses (3 set bits plus post) and 4 mm1_start pulses.
- Mode 1, same operands -> result = 71; exactly 5 mm0_start and 4 mm1_start pulses.
- Mode 0, mock latency L = 3, n = 4 -> done at cycle 21; busy high in cycles 1–20, low in cycle 21.
- exp_len = 0, and separately exp_len = 9 -> done = error = 1 at cycle 1, result = 0, no mm*_start.
- Mode 1, mm1_done delayed 5 cycles after mm0_done, plus start pulsed during WAIT -> result unchanged (71), next ISSUE exactly 1 cycle after mm1_done, extra start ignored.
- resetn low for 1 cycle during the second WAIT -> next cycle all outputs 0, state IDLE; a fresh start (mock also reset) returns 71.

Source files
------------

// File: rtl/mont_exp_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mont_exp_engine                                              |
// | Description : Modular-exponentiation sequencer (Montgomery domain). Walks  |
// |               the exponent bits and drives two external Montgomery         |
// |               multipliers through start/done handshakes. It supports       |
// |               right-to-left square-and-multiply and the Montgomery ladder, |
// |               then multiplies by 1 to leave the Montgomery domain.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mont_exp_engine #(
  parameter int WIDTH     = 1024,
  parameter int EXP_WIDTH = 1024,
  localparam int LW       = $clog2(EXP_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 mode,
  input  logic [EXP_WIDTH-1:0] exp,
  input  logic [LW-1:0]        exp_len,
  input  logic [WIDTH-1:0]     x_tilde,
  input  logic [WIDTH-1:0]     a_init,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [WIDTH-1:0]     result,
  output logic                 mm0_start,
  output logic                 mm1_start,
  output logic [WIDTH-1:0]     mm0_a,
  output logic [WIDTH-1:0]     mm0_b,
  output logic [WIDTH-1:0]     mm1_a,
  output logic [WIDTH-1:0]     mm1_b,
  input  logic                 mm0_done,
  input  logic                 mm1_done,
  input  logic [WIDTH-1:0]     mm0_result,
  input  logic [WIDTH-1:0]     mm1_result
);

  localparam logic [LW-1:0]    C_EXP_MAX = LW'(EXP_WIDTH);
  localparam logic [LW-1:0]    C_LEN_ONE = LW'(1);
  localparam logic [WIDTH-1:0] C_ONE     = WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ISSUE      = 3'd1,
    S_WAIT       = 3'd2,
    S_POST_ISSUE = 3'd3,
    S_POST_WAIT  = 3'd4,
    S_DONE       = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic                 mode_q, mode_d;
  logic [EXP_WIDTH-1:0] exp_q, exp_d;
  logic [LW-1:0]        len_q, len_d;
  logic [LW-1:0]        idx_q, idx_d;
  logic [WIDTH-1:0]     r0_q, r0_d;
  logic [WIDTH-1:0]     r1_q, r1_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 err_q, err_d;
  // Per-channel completion flags and captured results for the current bit
  logic                 d0_q, d0_d;
  logic                 d1_q, d1_d;
  logic [WIDTH-1:0]     res0_q, res0_d;
  logic [WIDTH-1:0]     res1_q, res1_d;

  logic                 w_bit;
  logic                 w_ch0_used;
  logic                 w_all_done;
  logic                 w_last_bit;
  logic [WIDTH-1:0]     w_res0;
  logic [WIDTH-1:0]     w_res1;

  // Select the current exponent bit; the index range is wider than the vector
  always_comb begin
    w_bit = 1'b0;
    for (int k = 0; k < EXP_WIDTH; k++) begin
      if (idx_q == LW'(k)) begin
        w_bit = exp_q[k];
      end
    end
  end

  // Per-bit bookkeeping: which channels run, and when this bit is finished
  always_comb begin
    w_ch0_used = mode_q | w_bit;
    // A result arriving this cycle is used directly; an earlier one was latched
    w_res0     = mm0_done ? mm0_result : res0_q;
    w_res1     = mm1_done ? mm1_result : res1_q;
    w_all_done = (~w_ch0_used | d0_q | mm0_done) & (d1_q | mm1_done);
    w_last_bit = mode_q ? (idx_q == '0) : (idx_q == (len_q - C_LEN_ONE));
  end

  // Next-state and datapath update for the sequencer
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    exp_d    = exp_q;
    len_d    = len_q;
    idx_d    = idx_q;
    r0_d     = r0_q;
    r1_d     = r1_q;
    result_d = result_q;
    err_d    = err_q;
    d0_d     = d0_q;
    d1_d     = d1_q;
    res0_d   = res0_q;
    res1_d   = res1_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d   = mode;
          exp_d    = exp;
          len_d    = exp_len;
          r0_d     = a_init;
          r1_d     = x_tilde;
          result_d = '0;
          if ((exp_len == '0) || (exp_len > C_EXP_MAX)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            idx_d   = mode ? (exp_len - C_LEN_ONE) : '0;
            state_d = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        d0_d    = 1'b0;
        d1_d    = 1'b0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (mm0_done && w_ch0_used) begin
          d0_d   = 1'b1;
          res0_d = mm0_result;
        end
        if (mm1_done) begin
          d1_d   = 1'b1;
          res1_d = mm1_result;
        end
        if (w_all_done) begin
          if (!mode_q) begin
            if (w_bit) begin
              r0_d = w_res0;
            end
            r1_d = w_res1;
          end else if (w_bit) begin
            r0_d = w_res0;
            r1_d = w_res1;
          end else begin
            r1_d = w_res0;
            r0_d = w_res1;
          end
          if (w_last_bit) begin
            state_d = S_POST_ISSUE;
          end else begin
            idx_d   = mode_q ? (idx_q - C_LEN_ONE) : (idx_q + C_LEN_ONE);
            state_d = S_ISSUE;
          end
        end
      end

      S_POST_ISSUE: begin
        state_d = S_POST_WAIT;
      end

      S_POST_WAIT: begin
        if (mm0_done) begin
          result_d = mm0_result;
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Multiplier operands and start pulses, derived from R0/R1 and state only
  always_comb begin
    mm0_start = 1'b0;
    mm1_start = 1'b0;
    mm0_a     = '0;
    mm0_b     = '0;
    mm1_a     = '0;
    mm1_b     = '0;
    case (state_q)
      S_ISSUE, S_WAIT: begin
        mm0_start = (state_q == S_ISSUE) && w_ch0_used;
        mm1_start = (state_q == S_ISSUE);
        mm0_a     = r0_q;
        mm0_b     = r1_q;
        // Ladder with a clear bit squares R0; every other case squares R1
        if (mode_q && !w_bit) begin
          mm1_a = r0_q;
          mm1_b = r0_q;
        end else begin
          mm1_a = r1_q;
          mm1_b = r1_q;
        end
      end
      S_POST_ISSUE, S_POST_WAIT: begin
        mm0_start = (state_q == S_POST_ISSUE);
        mm0_a     = r0_q;
        mm0_b     = C_ONE;
      end
      default: begin
      end
    endcase
  end

  // Status outputs
  always_comb begin
    busy   = (state_q != S_IDLE) && (state_q != S_DONE);
    done   = (state_q == S_DONE);
    error  = (state_q == S_DONE) && err_q;
    result = result_q;
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      mode_q   <= 1'b0;
      exp_q    <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      r0_q     <= '0;
      r1_q     <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      d0_q     <= 1'b0;
      d1_q     <= 1'b0;
      res0_q   <= '0;
      res1_q   <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      exp_q    <= exp_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      r0_q     <= r0_d;
      r1_q     <= r1_d;
      result_q <= result_d;
      err_q    <= err_d;
      d0_q     <= d0_d;
      d1_q     <= d1_d;
      res0_q   <= res0_d;
      res1_q   <= res1_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mont_exp_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mont_exp_engine                                           |
// | Description : Self-checking bench for mont_exp_engine with mock mod-97     |
// |               multipliers of programmable latency.                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mont_exp_engine;

  localparam int WIDTH     = 16;
  localparam int EXP_WIDTH = 8;
  localparam int LW        = $clog2(EXP_WIDTH + 1);

  logic                 clk = 1'b0;
  logic                 resetn = 1'b0;
  logic                 start = 1'b0;
  logic                 mode = 1'b0;
  logic [EXP_WIDTH-1:0] exp = '0;
  logic [LW-1:0]        exp_len = '0;
  logic [WIDTH-1:0]     x_tilde = '0;
  logic [WIDTH-1:0]     a_init = '0;
  logic                 busy, done, error;
  logic [WIDTH-1:0]     result;
  logic                 mm0_start, mm1_start;
  logic [WIDTH-1:0]     mm0_a, mm0_b, mm1_a, mm1_b;
  logic                 mm0_done, mm1_done;
  logic [WIDTH-1:0]     mm0_result, mm1_result;

  mont_exp_engine #(.WIDTH(WIDTH), .EXP_WIDTH(EXP_WIDTH)) dut (
    .clk(clk), .resetn(resetn), .start(start), .mode(mode), .exp(exp),
    .exp_len(exp_len), .x_tilde(x_tilde), .a_init(a_init),
    .busy(busy), .done(done), .error(error), .result(result),
    .mm0_start(mm0_start), .mm1_start(mm1_start),
    .mm0_a(mm0_a), .mm0_b(mm0_b), .mm1_a(mm1_a), .mm1_b(mm1_b),
    .mm0_done(mm0_done), .mm1_done(mm1_done),
    .mm0_result(mm0_result), .mm1_result(mm1_result)
  );

  always #5 clk = ~clk;

  // Mock multipliers: a*b mod 97, done pulse lat cycles after the start pulse
  int       lat0 = 1, lat1 = 1;
  int       c0, c1;
  logic     p0, p1;

  always @(posedge clk) begin
    if (!resetn) begin
      mm0_done <= 1'b0; p0 <= 1'b0; c0 <= 0; mm0_result <= '0;
      mm1_done <= 1'b0; p1 <= 1'b0; c1 <= 0; mm1_result <= '0;
    end else begin
      mm0_done <= 1'b0;
      mm1_done <= 1'b0;
      if (mm0_start) begin
        mm0_result <= 16'((32'(mm0_a) * 32'(mm0_b)) % 97);
        if (lat0 <= 1) mm0_done <= 1'b1;
        else begin p0 <= 1'b1; c0 <= lat0 - 1; end
      end else if (p0) begin
        if (c0 == 1) begin mm0_done <= 1'b1; p0 <= 1'b0; end
        else c0 <= c0 - 1;
      end
      if (mm1_start) begin
        mm1_result <= 16'((32'(mm1_a) * 32'(mm1_b)) % 97);
        if (lat1 <= 1) mm1_done <= 1'b1;
        else begin p1 <= 1'b1; c1 <= lat1 - 1; end
      end else if (p1) begin
        if (c1 == 1) begin mm1_done <= 1'b1; p1 <= 1'b0; end
        else c1 <= c1 - 1;
      end
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input longint act, input longint req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask

  // Observations from the last operation
  logic [WIDTH-1:0] o_res;
  logic             o_err;
  int               o_n0, o_n1, o_dc;
  bit               o_busy_bad, o_gap_bad, o_busy_at_done;

  task automatic run_op(input logic m, input logic [7:0] e, input logic [LW-1:0] n,
                        input logic [15:0] x, input int l0, input int l1, input bit poke);
    int last_d1;
    lat0 = l0; lat1 = l1;
    @(negedge clk);
    mode = m; exp = e; exp_len = n; x_tilde = x; a_init = 16'd1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    o_res = '1; o_err = 1'b0; o_n0 = 0; o_n1 = 0; o_dc = -1;
    o_busy_bad = 0; o_gap_bad = 0; o_busy_at_done = 1; last_d1 = -100;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (poke) start = (c == 3);
      if (mm0_start) o_n0++;
      if (mm1_start) o_n1++;
      if (c == last_d1 + 1 && !mm0_start && !mm1_start) o_gap_bad = 1;
      if (mm1_done) last_d1 = c;
      if (done) begin
        o_dc = c; o_res = result; o_err = error; o_busy_at_done = busy;
        break;
      end
      if (!busy) o_busy_bad = 1;
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic             m;
    logic [7:0]       e;
    logic [LW-1:0]    n;
    logic [15:0]      x;
    int               l0, l1;
    bit               poke;
    logic [15:0]      res;
    logic             er;
    int               n0, n1, dc;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [95:0] outs;
    vecs[0]  = '{1'b0, 8'b00001011, 4'd4, 16'd5, 1, 1, 0, 16'd71, 1'b0, 4, 4, 11};
    vecs[1]  = '{1'b1, 8'b00001011, 4'd4, 16'd5, 1, 1, 0, 16'd71, 1'b0, 5, 4, 11};
    vecs[2]  = '{1'b0, 8'b00001011, 4'd4, 16'd5, 3, 3, 0, 16'd71, 1'b0, 4, 4, 21};
    vecs[3]  = '{1'b0, 8'b00001011, 4'd0, 16'd5, 1, 1, 0, 16'd0,  1'b1, 0, 0, 1};
    vecs[4]  = '{1'b1, 8'b00001011, 4'd9, 16'd5, 1, 1, 0, 16'd0,  1'b1, 0, 0, 1};
    vecs[5]  = '{1'b1, 8'b00001011, 4'd4, 16'd5, 2, 7, 1, 16'd71, 1'b0, 5, 4, 36};
    vecs[6]  = '{1'b0, 8'hFF,       4'd8, 16'd3, 1, 1, 0, 16'd85, 1'b0, 9, 8, 19};
    vecs[7]  = '{1'b1, 8'hFF,       4'd8, 16'd3, 1, 1, 0, 16'd85, 1'b0, 9, 8, 19};
    vecs[8]  = '{1'b0, 8'hF3,       4'd2, 16'd5, 1, 1, 0, 16'd28, 1'b0, 3, 2, 7};
    vecs[9]  = '{1'b1, 8'hF3,       4'd2, 16'd5, 1, 1, 0, 16'd28, 1'b0, 3, 2, 7};
    vecs[10] = '{1'b0, 8'h00,       4'd3, 16'd5, 1, 1, 0, 16'd1,  1'b0, 1, 3, 9};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    outs = {busy, done, error, mm0_start, mm1_start, result, mm0_a, mm0_b, mm1_a, mm1_b};
    chk("reset_outputs", outs, 0);
    resetn = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].m, vecs[i].e, vecs[i].n, vecs[i].x, vecs[i].l0, vecs[i].l1, vecs[i].poke);
      chk($sformatf("v%0d_result", i), o_res, vecs[i].res);
      chk($sformatf("v%0d_error", i), o_err, vecs[i].er);
      chk($sformatf("v%0d_mm0_starts", i), o_n0, vecs[i].n0);
      chk($sformatf("v%0d_mm1_starts", i), o_n1, vecs[i].n1);
      chk($sformatf("v%0d_done_cycle", i), o_dc, vecs[i].dc);
      chk($sformatf("v%0d_busy_during", i), o_busy_bad, 0);
      chk($sformatf("v%0d_busy_at_done", i), o_busy_at_done, 0);
      chk($sformatf("v%0d_issue_gap", i), o_gap_bad, 0);
    end

    // Reset during the second WAIT of a mode-0, latency-3 operation
    lat0 = 3; lat1 = 3;
    @(negedge clk);
    mode = 1'b0; exp = 8'b00001011; exp_len = 4'd4; x_tilde = 16'd5; a_init = 16'd1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    resetn = 1'b0;
    @(negedge clk);
    outs = {busy, done, error, mm0_start, mm1_start, result, mm0_a, mm0_b, mm1_a, mm1_b};
    chk("midop_reset_outputs", outs, 0);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    chk("no_done_after_reset", {busy, done}, 0);
    run_op(1'b0, 8'b00001011, 4'd4, 16'd5, 1, 1, 0);
    chk("post_reset_result", o_res, 71);
    chk("post_reset_done_cycle", o_dc, 11);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
